triangle_setup: RTL and testbench

TRIANGLE_SETUP -- requirements
Module: triangle_setup

---
 rtl/gpu_pkg.sv | 25 ++
 rtl/edge_setup.sv | 38 +++
 rtl/triangle_setup.sv | 130 +++++++++++++
 tb/tb_triangle_setup.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared cull modes, width helpers and vertex/edge types for triangle setup
package gpu_pkg;
  typedef enum logic [1:0] {
    CULL_NONE = 2'd0,
    CULL_CW   = 2'd1,
    CULL_CCW  = 2'd2,
    CULL_RSVD = 2'd3
  } cull_mode_e;
  localparam int COORD_W = 16;
  function automatic int edge_w(input int cw);
    return cw + 1;
  endfunction
  function automatic int const_w(input int cw);
    return 2 * cw + 3;
  endfunction
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;
  typedef struct packed {
    logic signed [COORD_W:0]     a;
    logic signed [COORD_W:0]     b;
    logic signed [2*COORD_W+2:0] c;
  } edge_coef_t;
endpackage

// File: rtl/edge_setup.sv
// edge_setup: one edge equation; A/B registered in stage 1, C (plus aligned A/B) in stage 2
module edge_setup import gpu_pkg::*; #(
  parameter int COORD_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [COORD_WIDTH-1:0]         xi,
  input  logic [COORD_WIDTH-1:0]         yi,
  input  logic [COORD_WIDTH-1:0]         xj,
  input  logic [COORD_WIDTH-1:0]         yj,
  input  logic [COORD_WIDTH-1:0]         xs,
  input  logic [COORD_WIDTH-1:0]         ys,
  output logic signed [COORD_WIDTH:0]    a,
  output logic signed [COORD_WIDTH:0]    b,
  output logic signed [2*COORD_WIDTH+2:0] c
);
  localparam int EW = edge_w(COORD_WIDTH);
  localparam int KW = const_w(COORD_WIDTH);
  logic signed [EW-1:0] a1, b1;
  logic signed [KW-1:0] c_next;
  // xs/ys are the stage-1 copy of vertex i, aligned with a1/b1
  assign c_next = -(KW'(a1) * $signed(KW'({1'b0, xs})) + KW'(b1) * $signed(KW'({1'b0, ys})));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a1 <= '0;
      b1 <= '0;
      a  <= '0;
      b  <= '0;
      c  <= '0;
    end else if (en) begin
      a1 <= EW'(yi) - EW'(yj);
      b1 <= EW'(xj) - EW'(xi);
      a  <= a1;
      b  <= b1;
      c  <= c_next;
    end
endmodule

// File: rtl/triangle_setup.sv
// triangle_setup: 3-stage edge/area/bbox setup with culling, stall-on-backpressure and statistics
module triangle_setup import gpu_pkg::*; #(
  parameter int COORD_WIDTH   = 16,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [COORD_WIDTH-1:0]          vertexes [3][2],
  input  logic [1:0]                      cull_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [COORD_WIDTH:0]     edge_a [3],
  output logic signed [COORD_WIDTH:0]     edge_b [3],
  output logic signed [2*COORD_WIDTH+2:0] edge_c [3],
  output logic signed [2*COORD_WIDTH+2:0] area2,
  output logic [COORD_WIDTH-1:0]          bbox_min [2],
  output logic [COORD_WIDTH-1:0]          bbox_max [2],
  output logic [CNT_WIDTH-1:0]            tri_in_cnt,
  output logic [CNT_WIDTH-1:0]            tri_out_cnt,
  output logic [CNT_WIDTH-1:0]            tri_cull_cnt,
  output logic                            busy
);
  localparam int KW = const_w(COORD_WIDTH);
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(SCREEN_X_SIZE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(SCREEN_Y_SIZE - 1);
  logic                       en, cull, s1_valid, s2_valid;
  cull_mode_e                 s1_mode, s2_mode;
  logic [COORD_WIDTH-1:0]     s1_v [3][2];
  logic [COORD_WIDTH-1:0]     lo [2], hi [2], s2_min [2], s2_max [2];
  logic signed [KW-1:0]       dx1, dy1, dx2, dy2, area_next, s2_area;
  logic signed [COORD_WIDTH:0] ea [3], eb [3];
  logic signed [KW-1:0]       ec [3];
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign busy     = s1_valid || s2_valid || out_valid;
  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_setup #(.COORD_WIDTH(COORD_WIDTH)) u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .xi      (vertexes[i][0]),
      .yi      (vertexes[i][1]),
      .xj      (vertexes[(i+1)%3][0]),
      .yj      (vertexes[(i+1)%3][1]),
      .xs      (s1_v[i][0]),
      .ys      (s1_v[i][1]),
      .a       (ea[i]),
      .b       (eb[i]),
      .c       (ec[i])
    );
  end
  assign dx1       = KW'(s1_v[1][0]) - KW'(s1_v[0][0]);
  assign dy1       = KW'(s1_v[1][1]) - KW'(s1_v[0][1]);
  assign dx2       = KW'(s1_v[2][0]) - KW'(s1_v[0][0]);
  assign dy2       = KW'(s1_v[2][1]) - KW'(s1_v[0][1]);
  assign area_next = dx1 * dy2 - dx2 * dy1;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lo[k] = s1_v[0][k] < s1_v[1][k] ? s1_v[0][k] : s1_v[1][k];
      lo[k] = s1_v[2][k] < lo[k] ? s1_v[2][k] : lo[k];
      hi[k] = s1_v[0][k] > s1_v[1][k] ? s1_v[0][k] : s1_v[1][k];
      hi[k] = s1_v[2][k] > hi[k] ? s1_v[2][k] : hi[k];
    end
  end
  // Min is only compared against the screen edge, never clamped
  assign cull = s2_area == '0
             || (s2_mode == CULL_CW && s2_area[KW-1])
             || (s2_mode == CULL_CCW && !s2_area[KW-1])
             || s2_min[0] > X_LAST
             || s2_min[1] > Y_LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= CULL_NONE;
      for (int i = 0; i < 3; i++) s1_v[i] <= '{default: '0};
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= cull_mode_e'(cull_mode);
      s1_v     <= vertexes;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= CULL_NONE;
      s2_area  <= '0;
      s2_min   <= '{default: '0};
      s2_max   <= '{default: '0};
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_area   <= area_next;
      s2_min    <= lo;
      s2_max[0] <= hi[0] > X_LAST ? X_LAST : hi[0];
      s2_max[1] <= hi[1] > Y_LAST ? Y_LAST : hi[1];
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      edge_a    <= '{default: '0};
      edge_b    <= '{default: '0};
      edge_c    <= '{default: '0};
      area2     <= '0;
      bbox_min  <= '{default: '0};
      bbox_max  <= '{default: '0};
    end else if (en) begin
      out_valid <= s2_valid && !cull;
      if (s2_valid && !cull) begin
        edge_a   <= ea;
        edge_b   <= eb;
        edge_c   <= ec;
        area2    <= s2_area;
        bbox_min <= s2_min;
        bbox_max <= s2_max;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tri_in_cnt   <= '0;
      tri_out_cnt  <= '0;
      tri_cull_cnt <= '0;
    end else begin
      tri_in_cnt   <= tri_in_cnt + CNT_WIDTH'(in_valid && in_ready && !(&tri_in_cnt));
      tri_out_cnt  <= tri_out_cnt + CNT_WIDTH'(out_valid && out_ready && !(&tri_out_cnt));
      tri_cull_cnt <= tri_cull_cnt + CNT_WIDTH'(en && s2_valid && cull && !(&tri_cull_cnt));
    end
endmodule

// File: tb/tb_triangle_setup.sv
// tb_triangle_setup: directed + random checks of triangle_setup against an arithmetic reference model
module tb_triangle_setup;
  import gpu_pkg::*;
  typedef struct packed {
    vertex_t [2:0] v;
    logic [1:0]    mode;
  } tri_t;
  logic               clk = 1'b0;
  logic               reset_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0]        vertexes [3][2];
  logic [1:0]         cull_mode;
  logic signed [16:0] edge_a [3], edge_b [3];
  logic signed [34:0] edge_c [3];
  logic signed [34:0] area2;
  logic [15:0]        bbox_min [2], bbox_max [2];
  logic [15:0]        tri_in_cnt, tri_out_cnt, tri_cull_cnt;
  int     errors = 0, checks = 0;
  int     n_in = 0, n_out = 0, n_cull = 0;
  tri_t   exp_q [$];
  bit     held = 0, done = 0;
  longint snap_area, snap_c0, snap_a1, snap_bx;
  triangle_setup dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .vertexes(vertexes), .cull_mode(cull_mode), .out_valid(out_valid), .out_ready(out_ready),
    .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c), .area2(area2),
    .bbox_min(bbox_min), .bbox_max(bbox_max), .tri_in_cnt(tri_in_cnt),
    .tri_out_cnt(tri_out_cnt), .tri_cull_cnt(tri_cull_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  // Reference model: straight from the geometric definitions
  function automatic longint co(tri_t t, int i, int k);
    return k == 0 ? longint'(t.v[i].x) : longint'(t.v[i].y);
  endfunction
  function automatic longint m_a(tri_t t, int i);
    return co(t, i, 1) - co(t, (i + 1) % 3, 1);
  endfunction
  function automatic longint m_b(tri_t t, int i);
    return co(t, (i + 1) % 3, 0) - co(t, i, 0);
  endfunction
  function automatic longint m_c(tri_t t, int i);
    return -(m_a(t, i) * co(t, i, 0) + m_b(t, i) * co(t, i, 1));
  endfunction
  function automatic longint m_area(tri_t t);
    return (co(t,1,0) - co(t,0,0)) * (co(t,2,1) - co(t,0,1)) - (co(t,2,0) - co(t,0,0)) * (co(t,1,1) - co(t,0,1));
  endfunction
  function automatic longint m_lo(tri_t t, int k);
    longint m = co(t, 0, k);
    for (int i = 1; i < 3; i++) if (co(t, i, k) < m) m = co(t, i, k);
    return m;
  endfunction
  function automatic longint m_hi(tri_t t, int k);
    longint m = co(t, 0, k);
    longint lim = k == 0 ? 799 : 599;
    for (int i = 1; i < 3; i++) if (co(t, i, k) > m) m = co(t, i, k);
    return m > lim ? lim : m;
  endfunction
  function automatic bit m_cull(tri_t t);
    longint ar = m_area(t);
    return ar == 0 || (t.mode == 2'd1 && ar < 0) || (t.mode == 2'd2 && ar > 0)
        || m_lo(t, 0) >= 800 || m_lo(t, 1) >= 600;
  endfunction
  function automatic tri_t mk(int x0, int y0, int x1, int y1, int x2, int y2, int m);
    tri_t t;
    t.v[0].x = 16'(x0); t.v[0].y = 16'(y0);
    t.v[1].x = 16'(x1); t.v[1].y = 16'(y1);
    t.v[2].x = 16'(x2); t.v[2].y = 16'(y2);
    t.mode = 2'(m);
    return t;
  endfunction
  function automatic int rc(int lim);
    return $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, lim));
  endfunction
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input tri_t t);
    bit acc = 0;
    int g = 0;
    in_valid  = 1'b1;
    cull_mode = t.mode;
    for (int i = 0; i < 3; i++) begin
      vertexes[i][0] = t.v[i].x;
      vertexes[i][1] = t.v[i].y;
    end
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    chk("accept", longint'(acc), 1);
    if (acc) begin
      n_in++;
      if (m_cull(t)) n_cull++;
      else exp_q.push_back(t);
    end
  endtask
  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 200) begin
      step();
      g++;
    end
    chk("drain_pending", longint'(exp_q.size()) + longint'(busy), 0);
  endtask
  task automatic chk_counts();
    chk("tri_in_cnt", longint'(tri_in_cnt), n_in);
    chk("tri_out_cnt", longint'(tri_out_cnt), n_out);
    chk("tri_cull_cnt", longint'(tri_cull_cnt), n_cull);
  endtask
  // Output monitor: in-order scoreboard plus payload stability under backpressure
  always @(negedge clk) begin
    tri_t t;
    if (reset_n && held) begin
      chk("hold_area2", longint'(area2), snap_area);
      chk("hold_edge_c0", longint'(edge_c[0]), snap_c0);
      chk("hold_edge_a1", longint'(edge_a[1]), snap_a1);
      chk("hold_bbox_max_x", longint'(bbox_max[0]), snap_bx);
    end
    if (reset_n && out_valid && out_ready) begin
      chk("output_expected", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk("edge_a", longint'(edge_a[i]), m_a(t, i));
          chk("edge_b", longint'(edge_b[i]), m_b(t, i));
          chk("edge_c", longint'(edge_c[i]), m_c(t, i));
        end
        chk("area2", longint'(area2), m_area(t));
        for (int k = 0; k < 2; k++) begin
          chk("bbox_min", longint'(bbox_min[k]), m_lo(t, k));
          chk("bbox_max", longint'(bbox_max[k]), m_hi(t, k));
        end
      end
      n_out++;
    end
    held      = reset_n && out_valid && !out_ready;
    snap_area = longint'(area2);
    snap_c0   = longint'(edge_c[0]);
    snap_a1   = longint'(edge_a[1]);
    snap_bx   = longint'(bbox_max[0]);
  end
  initial begin
    tri_t t;
    tri_t bp [10];
    int   base;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cull_mode = 2'd0;
    vertexes  = '{default: '0};
    repeat (2) step();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_area2", longint'(area2), 0);
    chk("rst_edge_c1", longint'(edge_c[1]), 0);
    chk_counts();
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", longint'(in_ready), 1);
    // Right triangle: latency and exact coefficients
    t = mk(0, 0, 10, 0, 0, 10, 0);
    send(t);
    chk("lat_n1", longint'(out_valid), 0);
    step();
    chk("lat_n2", longint'(out_valid), 0);
    step();
    chk("lat_n3", longint'(out_valid), 1);
    chk("k_a0", longint'(edge_a[0]), 0);
    chk("k_a1", longint'(edge_a[1]), -10);
    chk("k_a2", longint'(edge_a[2]), 10);
    chk("k_b0", longint'(edge_b[0]), 10);
    chk("k_b1", longint'(edge_b[1]), -10);
    chk("k_b2", longint'(edge_b[2]), 0);
    chk("k_c1", longint'(edge_c[1]), 100);
    chk("k_area2", longint'(area2), 100);
    chk("k_bbox_max_y", longint'(bbox_max[1]), 10);
    drain();
    send(mk(0, 0, 10, 0, 0, 10, 2));
    drain();
    chk("ccw_cull_cnt", longint'(tri_cull_cnt), 1);
    chk("ccw_out_cnt", longint'(tri_out_cnt), 1);
    send(mk(0, 0, 10, 0, 0, 10, 1));
    drain();
    chk("cw_mode_out_cnt", longint'(tri_out_cnt), 2);
    send(mk(0, 0, 5, 5, 10, 10, 0));
    drain();
    chk("collinear_out_cnt", longint'(tri_out_cnt), 2);
    chk("collinear_cull_cnt", longint'(tri_cull_cnt), 2);
    // Horizontal clamp, then fully off the right edge
    send(mk(100, 100, 900, 200, 300, 400, 0));
    repeat (2) step();
    chk("clamp_max_x", longint'(bbox_max[0]), 799);
    chk("clamp_min_x", longint'(bbox_min[0]), 100);
    drain();
    send(mk(800, 10, 900, 20, 850, 50, 0));
    drain();
    chk("offscreen_cull_cnt", longint'(tri_cull_cnt), 3);
    chk_counts();
    // Back-to-back stream with a 5-cycle downstream stall
    for (int i = 0; i < 10; i++) begin
      int g = 0;
      do begin
        bp[i] = mk($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 700),
                   $urandom_range(0, 500), $urandom_range(0, 700), $urandom_range(0, 500), 0);
        g++;
      end while (m_area(bp[i]) == 0 && g < 20);
    end
    base = n_out;
    fork
      for (int i = 0; i < 10; i++) send(bp[i]);
      begin
        repeat (4) step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", longint'(in_ready), 0);
        chk("stall_out_valid", longint'(out_valid), 1);
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_all_out", longint'(n_out - base), longint'(10 - (n_cull - 3)));
    // Random triangles and modes under random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          t = mk(rc(900), rc(700), rc(900), rc(700), rc(900), rc(700), $urandom_range(0, 3));
          send(t);
        end
        done = 1;
      end
      while (!done) begin
        out_ready = $urandom_range(0, 3) != 0;
        step();
      end
    join
    out_ready = 1'b1;
    drain();
    chk_counts();
    // Reset with three triangles in flight
    for (int i = 0; i < 3; i++) send(mk(0, 0, 10, 0, 0, 10, 0));
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_in = 0;
    n_out = 0;
    n_cull = 0;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk_counts();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_in_ready", longint'(in_ready), 1);
    send(mk(20, 30, 40, 30, 20, 60, 0));
    drain();
    chk_counts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
